// File: rtl/gear_selector_fsm.sv
// PRND gear selector: debounced selector/shift inputs, Park/Reverse/Neutral/Drive FSM, 7-seg glyph.
// Optional brake interlock enabled by defining GEAR_SEL_INTERLOCK_EN.
module gear_selector_fsm #(
    parameter int unsigned DEB_CYCLES     = 50000,
    parameter int unsigned NUM_DRIVE      = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       shift_up,
    input  logic       shift_down,
    input  logic       brake,
    output logic [6:0] led,
    output logic [3:0] gear,
    output logic       fault
);
    localparam int unsigned     NB       = 6;
    localparam int unsigned     CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [3:0]      TOP_GEAR = 4'(NUM_DRIVE);
    localparam logic [6:0]      GLYPH_P  = 7'b1110011;

    typedef enum logic [1:0] {PARK, REV, NEUT, DRIVE} state_t;

    logic [NB-1:0] raw, sync1, sync2, deb;
    logic [CW-1:0] cnt [NB];

    assign raw = {shift_down, shift_up, sw};

    // Counter only runs while the synced bit disagrees with the debounced bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef GEAR_SEL_INTERLOCK_EN
    logic brake_s1, brake_s2;
    always_ff @(posedge clk) begin
        if (reset) begin
            brake_s1 <= 1'b0;
            brake_s2 <= 1'b0;
        end else begin
            brake_s1 <= brake;
            brake_s2 <= brake_s1;
        end
    end
`else
    logic brake_unused;
    assign brake_unused = brake;
`endif

    state_t     state_q, state_d, req_state;
    logic [3:0] dgear_q, dgear_d;
    logic       up_prev, down_prev, fault_st_q;
    logic [3:0] sel;
    logic       sel_onehot, sel_multi, up_edge, down_edge, req_change, allow;

    assign sel = deb[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PARK;
            dgear_q    <= '0;
            up_prev    <= 1'b0;
            down_prev  <= 1'b0;
            fault_st_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dgear_q    <= dgear_d;
            up_prev    <= deb[4];
            down_prev  <= deb[5];
            fault_st_q <= sel_multi;
        end
    end

    always_comb begin
        sel_onehot = (sel != '0) && ((sel & (sel - 4'd1)) == '0);
        sel_multi  = (sel != '0) && !sel_onehot;
        up_edge    = deb[4] & ~up_prev;
        down_edge  = deb[5] & ~down_prev;
        case (sel)
            4'b1000: req_state = PARK;
            4'b0100: req_state = REV;
            4'b0010: req_state = NEUT;
            default: req_state = DRIVE;
        endcase
        req_change = sel_onehot && (req_state != state_q);
`ifdef GEAR_SEL_INTERLOCK_EN
        allow = brake_s2 || ((state_q != PARK) && (req_state != REV));
`else
        allow = 1'b1;
`endif
        state_d = state_q;
        dgear_d = dgear_q;
        // A differing request (even one held off by the interlock) swallows shift edges.
        if (req_change) begin
            if (allow) begin
                state_d = req_state;
                dgear_d = (req_state == DRIVE) ? 4'd1 : 4'd0;
            end
        end else if ((state_q == DRIVE) && (up_edge ^ down_edge)) begin
            if (up_edge && (dgear_q < TOP_GEAR)) begin
                dgear_d = dgear_q + 4'd1;
            end else if (down_edge && (dgear_q > 4'd1)) begin
                dgear_d = dgear_q - 4'd1;
            end
        end
    end

    logic [3:0] gear_d;
    logic [6:0] glyph, led_d;

    always_comb begin
        case (state_q)
            PARK:    gear_d = 4'hF;
            REV:     gear_d = 4'hE;
            NEUT:    gear_d = 4'h0;
            default: gear_d = dgear_q;
        endcase
        case (gear_d)
            4'hF:    glyph = GLYPH_P;
            4'hE:    glyph = 7'b1010000;
            4'h0:    glyph = 7'b1010100;
            4'h1:    glyph = 7'b0000110;
            4'h2:    glyph = 7'b1011011;
            4'h3:    glyph = 7'b1001111;
            4'h4:    glyph = 7'b1100110;
            4'h5:    glyph = 7'b1101101;
            4'h6:    glyph = 7'b1111101;
            4'h7:    glyph = 7'b0000111;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1101111;
            default: glyph = 7'b1000000;
        endcase
        if (fault_st_q) glyph = 7'b1000000;
        led_d = SEG_ACTIVE_LOW ? ~glyph : glyph;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gear  <= 4'hF;
            led   <= SEG_ACTIVE_LOW ? ~GLYPH_P : GLYPH_P;
            fault <= 1'b0;
        end else begin
            gear  <= gear_d;
            led   <= led_d;
            fault <= fault_st_q;
        end
    end

endmodule

// File: tb/tb_gear_selector_fsm.sv
// Self-checking bench for gear_selector_fsm: history-based reference model checked every cycle,
// plus literal checkpoints along a directed scenario.
module tb_gear_selector_fsm;
    localparam int unsigned DEB = 4;
    localparam int unsigned ND  = 4;
`ifdef GEAR_SEL_INTERLOCK_EN
    localparam bit INTERLOCK = 1'b1;
`else
    localparam bit INTERLOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = 4'b1000;
    logic       shift_up = 1'b0, shift_down = 1'b0, brake = 1'b1;
    logic [6:0] led;
    logic [3:0] gear;
    logic       fault;

    int passed = 0;
    int total  = 0;

    gear_selector_fsm #(.DEB_CYCLES(DEB), .NUM_DRIVE(ND), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .sw(sw), .shift_up(shift_up), .shift_down(shift_down),
        .brake(brake), .led(led), .gear(gear), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_of(input logic [3:0] g, input logic f);
        if (f) return 7'b1000000;
        case (g)
            4'hF: return 7'b1110011;
            4'hE: return 7'b1010000;
            4'h0: return 7'b1010100;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Raw samples {brake, down, up, sw}, one per edge; the last entry is the previous edge.
    logic [6:0] hist [$];
    logic [5:0] m_deb, m_prev;
    logic [3:0] m_cur, exp_gear;
    logic       m_fst, exp_fault;
    logic       started = 1'b0;

    // A bit flips once the synchronised value seen on the last DEB edges all disagreed with it.
    function automatic logic [5:0] deb_next(input logic [5:0] cur);
        logic [5:0] r;
        r = cur;
        for (int b = 0; b < 6; b++) begin
            bit flip;
            flip = 1'b1;
            for (int k = 2; k <= DEB + 1; k++)
                if (hist[hist.size() - k][b] == cur[b]) flip = 1'b0;
            if (flip) r[b] = ~cur[b];
        end
        return r;
    endfunction

    // State is represented directly by the gear code: F=P, E=R, 0=N, 1..9=drive gear.
    function automatic logic [3:0] next_gear(input logic [3:0] cur, input logic [5:0] d,
                                             input logic [5:0] p, input logic bs);
        logic [3:0] tgt;
        logic in_drive, up, dn, same;
        in_drive = (cur >= 4'd1) && (cur <= 4'd9);
        up = d[4] && !p[4];
        dn = d[5] && !p[5];
        if ($countones(d[3:0]) == 1) begin
            tgt  = d[3] ? 4'hF : d[2] ? 4'hE : d[1] ? 4'h0 : 4'h1;
            same = (tgt == 4'h1) ? in_drive : (tgt == cur);
            if (!same) begin
                if (INTERLOCK && !bs && (cur == 4'hF || tgt == 4'hE)) return cur;
                return tgt;
            end
        end
        if (in_drive && up && !dn) return (cur < 4'(ND)) ? cur + 4'd1 : cur;
        if (in_drive && dn && !up) return (cur > 4'd1) ? cur - 4'd1 : cur;
        return cur;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            for (int k = 0; k < DEB + 2; k++) hist.push_back(7'd0);
            m_deb     <= '0;
            m_prev    <= '0;
            m_cur     <= 4'hF;
            m_fst     <= 1'b0;
            exp_gear  <= 4'hF;
            exp_fault <= 1'b0;
            started   <= 1'b1;
        end else if (started) begin
            exp_gear  <= m_cur;
            exp_fault <= m_fst;
            m_cur     <= next_gear(m_cur, m_deb, m_prev, hist[hist.size() - 2][6]);
            m_fst     <= ($countones(m_deb[3:0]) > 1);
            m_prev    <= m_deb;
            m_deb     <= deb_next(m_deb);
            hist.push_back({brake, shift_down, shift_up, sw});
            if (hist.size() > DEB + 4) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (started) begin
            total++;
            if (gear === exp_gear && fault === exp_fault && led === glyph_of(exp_gear, exp_fault))
                passed++;
            else
                $display("FAIL model t=%0t gear=%h/%h fault=%b/%b led=%b/%b (got/exp)", $time,
                         gear, exp_gear, fault, exp_fault, led, glyph_of(exp_gear, exp_fault));
        end
    end

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%b exp=%b", name, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic dn);
        shift_up = up; shift_down = dn;
        cyc(6);
        shift_up = 1'b0; shift_down = 1'b0;
        cyc(6);
    endtask

    initial begin
        // 1: reset
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("reset_gear", 7'(gear), 7'h0F);
        chk("reset_led", led, 7'b1110011);
        chk("reset_fault", 7'(fault), 7'd0);

        // 2: neutral, drive, shifting with saturation
        sw = 4'b0010; cyc(12);
        chk("neut_gear", 7'(gear), 7'h00);
        sw = 4'b0001; cyc(12);
        chk("drive_gear", 7'(gear), 7'h01);
        chk("drive_led", led, 7'b0000110);
        repeat (5) press(1'b1, 1'b0);
        chk("up_sat", 7'(gear), 7'h04);
        press(1'b1, 1'b1);
        chk("both_ignored", 7'(gear), 7'h04);
        repeat (5) press(1'b0, 1'b1);
        chk("down_sat", 7'(gear), 7'h01);

        // 3: short glitches do not change state
        sw = 4'b0010; cyc(12);
        repeat (3) begin
            sw = 4'b0001; cyc(3);
            sw = 4'b0010; cyc(5);
        end
        cyc(6);
        chk("glitch_hold", 7'(gear), 7'h00);
        sw = 4'b0001; cyc(12);
        chk("glitch_then_drive", 7'(gear), 7'h01);

        // 4: invalid combination
        sw = 4'b1001; cyc(12);
        chk("fault_set", 7'(fault), 7'd1);
        chk("fault_led", led, 7'b1000000);
        chk("fault_gear_hold", 7'(gear), 7'h01);
        sw = 4'b0010; cyc(12);
        chk("fault_clear", 7'(fault), 7'd0);
        chk("fault_to_neut", 7'(gear), 7'h00);

        // 5: reverse from park with brake released, then pressed
        sw = 4'b1000; cyc(12);
        chk("park_again", 7'(gear), 7'h0F);
        brake = 1'b0;
        sw = 4'b0100; cyc(20);
        chk("rev_no_brake", 7'(gear), INTERLOCK ? 7'h0F : 7'h0E);
        brake = 1'b1; cyc(4);
        chk("rev_brake", 7'(gear), 7'h0E);

        // 6: reset mid-drive during a pending shift debounce
        sw = 4'b0001; cyc(12);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("drive3", 7'(gear), 7'h03);
        shift_up = 1'b1; cyc(4);
        reset = 1'b1; shift_up = 1'b0; cyc(1);
        chk("reset_mid_gear", 7'(gear), 7'h0F);
        chk("reset_mid_led", led, 7'b1110011);
        reset = 1'b0; cyc(14);
        chk("after_reset_drive", 7'(gear), 7'h01);

        cyc(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
